// File: rtl/taxi_reset_seq.sv
// ============================================================================
// Module   : taxi_reset_seq
// Purpose  : Ordered, spaced release of N_OUT reset domains after clock lock.
//            Optional statistics outputs under `TAXI_RST_SEQ_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module taxi_reset_seq #(
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             sw_rst,
    output logic [N_OUT-1:0] rst_out,
    output logic             done,
    output logic             busy
`ifdef TAXI_RST_SEQ_STATS_EN
    ,
    output logic [15:0]      abort_count,
    output logic [15:0]      seq_count
`endif
);

    localparam int c_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W = $clog2(c_MAX + 1);

    localparam logic [CNT_W-1:0] c_HOLD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_STEP = CNT_W'(STEP_CYCLES);
    localparam logic [N_OUT-1:0] c_ONES = '1;
    // Only the top domain still held: the next release finishes the sequence.
    localparam logic [N_OUT-1:0] c_LAST = ~(c_ONES >> 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_OUT-1:0] r_rst_out;
    logic             r_done;
    logic             r_busy;

    logic             w_abort;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_abort   = ~locked | sw_rst;
    assign w_cnt_inc = r_cnt + 1'b1;

    // The thermometer code in r_rst_out doubles as the release index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
        end else if (w_abort) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (w_cnt_inc == c_HOLD) begin
                        r_cnt     <= '0;
                        r_rst_out <= r_rst_out << 1;
                        if (N_OUT == 1) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RELEASE: begin
                    if (w_cnt_inc == c_STEP) begin
                        r_cnt     <= '0;
                        r_rst_out <= r_rst_out << 1;
                        if (r_rst_out == c_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state   <= S_HOLD;
                    r_cnt     <= '0;
                    r_rst_out <= '1;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign done    = r_done;
    assign busy    = r_busy;

`ifdef TAXI_RST_SEQ_STATS_EN
    logic [15:0] r_abort_count;
    logic [15:0] r_seq_count;
    logic        w_count_abort;
    logic        w_enter_done;

    // An abort from HOLD with an empty counter throws away no progress.
    assign w_count_abort = w_abort & ((r_state != S_HOLD) | (r_cnt != '0));
    assign w_enter_done  = ~w_abort &
        (((r_state == S_HOLD) & (w_cnt_inc == c_HOLD) & (N_OUT == 1)) |
         ((r_state == S_RELEASE) & (w_cnt_inc == c_STEP) & (r_rst_out == c_LAST)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_abort_count <= '0;
            r_seq_count   <= '0;
        end else begin
            if (w_count_abort && r_abort_count != 16'hFFFF) begin
                r_abort_count <= r_abort_count + 16'd1;
            end
            if (w_enter_done && r_seq_count != 16'hFFFF) begin
                r_seq_count <= r_seq_count + 16'd1;
            end
        end
    end

    assign abort_count = r_abort_count;
    assign seq_count   = r_seq_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_taxi_reset_seq.sv
// Bench for taxi_reset_seq: directed timing scenarios plus randomized lock/sw_rst/rst
// traffic, checked against a model based on consecutive non-abort edges.
`default_nettype none

module tb_taxi_reset_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b1;
    logic       sw_rst = 1'b0;
    logic [3:0] rst_out;
    logic       done, busy;
    logic [0:0] rst_out1;
    logic       done1, busy1;
`ifdef TAXI_RST_SEQ_STATS_EN
    logic [15:0] abort_count, seq_count, abort_count1, seq_count1;
    logic [15:0] saved_abort;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    taxi_reset_seq #(.N_OUT(4), .HOLD_CYCLES(16), .STEP_CYCLES(8)) u_dut (
        .clk(clk), .rst(rst), .locked(locked), .sw_rst(sw_rst),
        .rst_out(rst_out), .done(done), .busy(busy)
`ifdef TAXI_RST_SEQ_STATS_EN
        , .abort_count(abort_count), .seq_count(seq_count)
`endif
    );

    taxi_reset_seq #(.N_OUT(1), .HOLD_CYCLES(1), .STEP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .locked(locked), .sw_rst(sw_rst),
        .rst_out(rst_out1), .done(done1), .busy(busy1)
`ifdef TAXI_RST_SEQ_STATS_EN
        , .abort_count(abort_count1), .seq_count(seq_count1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Domains released after t consecutive good edges: first at HOLD, then every STEP.
    function automatic int nrel(input int t, input int n, input int h, input int s);
        int r;
        if (t < h) return 0;
        r = 1 + (t - h) / s;
        return (r > n) ? n : r;
    endfunction

    int t = 0;
    int m_abort = 0, m_seq = 0, m_seq1 = 0;

    always @(posedge clk or posedge rst) begin
        int old;
        if (rst) begin
            t = 0; m_abort = 0; m_seq = 0; m_seq1 = 0;
        end else if (!locked || sw_rst) begin
            if (t > 0 && m_abort < 65535) m_abort++;
            t = 0;
        end else begin
            old = t;
            if (t < 100000) t++;
            if (nrel(old, 4, 16, 8) < 4 && nrel(t, 4, 16, 8) == 4 && m_seq < 65535) m_seq++;
            if (nrel(old, 1, 1, 1) < 1 && nrel(t, 1, 1, 1) == 1 && m_seq1 < 65535) m_seq1++;
        end
    end

    always @(negedge clk) begin
        int n, n1;
        logic [31:0] tmp;
        logic [3:0]  e, w;
        n   = nrel(t, 4, 16, 8);
        n1  = nrel(t, 1, 1, 1);
        tmp = 32'hF << n;
        e   = tmp[3:0];
        w   = ~rst_out;
        chk("model_rst_out", {28'd0, rst_out}, {28'd0, e});
        chk("model_done", {31'd0, done}, (n == 4) ? 32'd1 : 32'd0);
        chk("model_busy", {31'd0, busy}, (n == 4) ? 32'd0 : 32'd1);
        chk("thermometer", {28'd0, w & (w + 4'd1)}, 32'd0);
        chk("model_rst_out_n1", {31'd0, rst_out1}, (n1 == 1) ? 32'd0 : 32'd1);
        chk("model_done_n1", {31'd0, done1}, (n1 == 1) ? 32'd1 : 32'd0);
        chk("model_busy_n1", {31'd0, busy1}, (n1 == 1) ? 32'd0 : 32'd1);
`ifdef TAXI_RST_SEQ_STATS_EN
        chk("model_abort_count", {16'd0, abort_count}, m_abort);
        chk("model_seq_count", {16'd0, seq_count}, m_seq);
        chk("model_abort_count_n1", {16'd0, abort_count1}, m_abort);
        chk("model_seq_count_n1", {16'd0, seq_count1}, m_seq1);
`endif
    end

    // Called just after the edge that starts a fresh sequence, with locked=1 and sw_rst=0.
    task automatic run_seq(input string tag);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            case (k)
                1:  chk($sformatf("%s_n1_done_k1", tag), {31'd0, done1}, 32'd1);
                15: chk($sformatf("%s_k15", tag), {28'd0, rst_out}, 32'hF);
                16: chk($sformatf("%s_k16", tag), {28'd0, rst_out}, 32'hE);
                23: chk($sformatf("%s_k23", tag), {28'd0, rst_out}, 32'hE);
                24: chk($sformatf("%s_k24", tag), {28'd0, rst_out}, 32'hC);
                32: chk($sformatf("%s_k32", tag), {28'd0, rst_out}, 32'h8);
                39: chk($sformatf("%s_k39_done", tag), {31'd0, done}, 32'd0);
                40: begin
                    chk($sformatf("%s_k40", tag), {28'd0, rst_out}, 32'h0);
                    chk($sformatf("%s_k40_done", tag), {31'd0, done}, 32'd1);
                    chk($sformatf("%s_k40_busy", tag), {31'd0, busy}, 32'd0);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_out", {28'd0, rst_out}, 32'hF);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_rst_out_n1", {31'd0, rst_out1}, 32'd1);
        #1 rst = 1'b0;
        run_seq("s1");

        // Software reset pulse while DONE.
        repeat (3) @(posedge clk);
        #2 sw_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s3_abort_rst_out", {28'd0, rst_out}, 32'hF);
        chk("s3_abort_done", {31'd0, done}, 32'd0);
        #1 sw_rst = 1'b0;
        run_seq("s3");
`ifdef TAXI_RST_SEQ_STATS_EN
        chk("s3_abort_count", {16'd0, abort_count}, 32'd1);
        chk("s3_seq_count", {16'd0, seq_count}, 32'd2);
`endif

        // Combined locked drop and sw_rst during RELEASE.
        #1 sw_rst = 1'b1;
        @(posedge clk);
        #2 sw_rst = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        chk("s4_pre_rst_out", {28'd0, rst_out}, 32'hC);
`ifdef TAXI_RST_SEQ_STATS_EN
        saved_abort = abort_count;
`endif
        #1 begin locked = 1'b0; sw_rst = 1'b1; end
        @(posedge clk);
        #1;
        chk("s4_abort_rst_out", {28'd0, rst_out}, 32'hF);
`ifdef TAXI_RST_SEQ_STATS_EN
        chk("s4_abort_once", {16'd0, abort_count}, {16'd0, saved_abort + 16'd1});
`endif
        #1 begin locked = 1'b1; sw_rst = 1'b0; end

        // One-cycle lock loss in HOLD restarts the hold count.
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 26) chk("s2_k26", {28'd0, rst_out}, 32'hF);
            if (k == 27) chk("s2_k27", {28'd0, rst_out}, 32'hE);
            if (k == 10) #1 locked = 1'b0;
            if (k == 11) #1 locked = 1'b1;
        end

        // Asynchronous rst between edges while releasing.
        repeat (5) @(posedge clk);
        #1 chk("s5_pre_rst_out", {28'd0, rst_out}, 32'hC);
        #6 rst = 1'b1;
        #1;
        chk("s5_async_rst_out", {28'd0, rst_out}, 32'hF);
        chk("s5_async_done", {31'd0, done}, 32'd0);
        chk("s5_async_n1", {31'd0, rst_out1}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        run_seq("s5");

        // Randomized lock, software and hardware reset traffic.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            locked = ($urandom_range(31) != 0);
            sw_rst = ($urandom_range(63) == 0);
            rst    = ($urandom_range(499) == 0);
        end
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
